// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory slave: accepts one load/store, commits it after a
// fixed latency, pulses ready for one cycle and stalls the pipeline meanwhile.
module data_mem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam bit         SINGLE   = (LATENCY == 1);

  stateT             state, nextState;
  logic [3:0]        cnt;
  logic [ADDR_W+1:0] capAddr;
  logic [31:0]       capWdata;
  logic              capRead, capWrite;
  logic [31:0]       mem [2**ADDR_W];

  logic              req, accept, commit;
  logic [ADDR_W+1:0] opAddr;
  logic [31:0]       opWdata;
  logic              opRead, opWrite, opErr;
  logic [ADDR_W-1:0] idx;
  logic              addrHiUnused;

  assign req          = MemRead | MemWrite;
  assign accept       = (state == IDLE) & req;
  assign addrHiUnused = ^addr[31:ADDR_W+2];

  // State register and latency counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= nextState;
      if (accept)
        cnt <= CNT_INIT;
      else if (state == BUSY)
        cnt <= cnt - 4'd1;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (req) nextState = SINGLE ? DONE : BUSY;
      BUSY:    if (cnt == 4'd1) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    stall = ~reset & (accept | (state == BUSY));
  end

  // Request capture; data only, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      capAddr  <= addr[ADDR_W+1:0];
      capWdata <= wdata;
      capRead  <= MemRead;
      capWrite <= MemWrite;
    end
  end

  // With LATENCY=1 the commit edge is the acceptance edge, so use live inputs
  always_comb begin
    if (state == IDLE) begin
      opAddr  = addr[ADDR_W+1:0];
      opWdata = wdata;
      opRead  = MemRead;
      opWrite = MemWrite;
    end else begin
      opAddr  = capAddr;
      opWdata = capWdata;
      opRead  = capRead;
      opWrite = capWrite;
    end
    idx    = opAddr[ADDR_W+1:2];
    opErr  = (opAddr[1:0] != 2'b00) | (opRead & opWrite);
    commit = ~reset & (nextState == DONE);
  end

  // Commit edge: completion flags and load data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata <= 32'h0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      ready <= commit;
      err   <= commit & opErr;
      if (commit & opRead & ~opErr)
        rdata <= mem[idx];
    end
  end

  // Memory contents survive reset
  always_ff @(posedge clk) begin
    if (commit & opWrite & ~opErr)
      mem[idx] <= opWdata;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: a LATENCY=2 instance for the main
// sequence and a LATENCY=1 instance for back-to-back throughput.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite;
  logic [31:0] addr, wdata, rdata;
  logic        ready, err, stall;
  logic        MemRead1, MemWrite1;
  logic [31:0] addr1, wdata1, rdata1;
  logic        ready1, err1, stall1;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(8), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready), .err(err),
    .stall(stall)
  );

  data_mem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .MemRead(MemRead1), .MemWrite(MemWrite1),
    .addr(addr1), .wdata(wdata1), .rdata(rdata1), .ready(ready1), .err(err1),
    .stall(stall1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One access on the LATENCY=2 instance; returns DONE-cycle err/rdata.
  task automatic access(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, output logic errO, output logic [31:0] rdO);
    int lat;
    MemRead = rd; MemWrite = wr; addr = a; wdata = d;
    @(negedge clk);
    chk("stallAccept", {31'd0, stall}, 32'd1);
    cyc();
    MemRead = 1'b0; MemWrite = 1'b0;
    lat = 1;
    while (!ready && lat < 20) begin
      chk("stallBusy", {31'd0, stall}, 32'd1);
      cyc();
      lat++;
    end
    chk("latency", lat, 32'd2);
    chk("stallDone", {31'd0, stall}, 32'd0);
    errO = err;
    rdO  = rdata;
    cyc();
    chk("readyPulse", {30'd0, ready, err}, 32'd0);
  endtask

  logic        e;
  logic [31:0] r, r0;
  logic        sawReady;

  initial begin
    reset = 1'b1;
    MemRead = 1'b0; MemWrite = 1'b1; addr = 32'h10; wdata = 32'h0;
    MemRead1 = 1'b0; MemWrite1 = 1'b1; addr1 = 32'h0; wdata1 = 32'h0;
    cyc(); cyc();
    chk("rstRdata", rdata, 32'h0);
    chk("rstReadyErr", {30'd0, ready, err}, 32'd0);
    chk("rstStall", {31'd0, stall}, 32'd0);
    chk("rstStall1", {31'd0, stall1}, 32'd0);
    MemWrite = 1'b0; MemWrite1 = 1'b0;
    reset = 1'b0;
    cyc();

    // Store then load
    access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, e, r);
    chk("storeErr", {31'd0, e}, 32'd0);
    access(1'b1, 1'b0, 32'h10, 32'h0, e, r);
    chk("loadErr", {31'd0, e}, 32'd0);
    chk("loadData", r, 32'hDEADBEEF);

    // Misaligned store suppressed
    access(1'b0, 1'b1, 32'h13, 32'h11111111, e, r);
    chk("misStoreErr", {31'd0, e}, 32'd1);
    chk("misStoreRdata", r, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h10, 32'h0, e, r);
    chk("afterMisLoad", r, 32'hDEADBEEF);

    // Conflicting request: error, no write, rdata unchanged
    access(1'b0, 1'b1, 32'h14, 32'hCAFEF00D, e, r);
    access(1'b1, 1'b1, 32'h14, 32'h0BADBAD0, e, r);
    chk("conflictErr", {31'd0, e}, 32'd1);
    chk("conflictRdata", r, 32'hDEADBEEF);
    access(1'b1, 1'b0, 32'h14, 32'h0, e, r);
    chk("afterConflictLoad", r, 32'hCAFEF00D);

    // Misaligned load keeps rdata
    access(1'b1, 1'b0, 32'h12, 32'h0, e, r);
    chk("misLoadErr", {31'd0, e}, 32'd1);
    chk("misLoadRdata", r, 32'hCAFEF00D);

    // Address wrap
    access(1'b0, 1'b1, 32'h400, 32'h55, e, r);
    access(1'b1, 1'b0, 32'h000, 32'h0, e, r);
    chk("wrapLoad", r, 32'h00000055);
    chk("wrapErr", {31'd0, e}, 32'd0);

    // Reset during BUSY abandons the store
    access(1'b0, 1'b1, 32'h20, 32'h0F0F0F0F, e, r);
    MemWrite = 1'b1; addr = 32'h20; wdata = 32'h12345678;
    cyc();
    MemWrite = 1'b0;
    chk("busyStall", {31'd0, stall}, 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("midRstRdata", rdata, 32'h0);
    chk("midRstFlags", {29'd0, stall, ready, err}, 32'd0);
    cyc(); cyc();
    reset = 1'b0;
    sawReady = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (ready) sawReady = 1'b1;
      cyc();
    end
    chk("noReadyAfterRst", {31'd0, sawReady}, 32'd0);
    access(1'b1, 1'b0, 32'h20, 32'h0, e, r);
    chk("rstKeepsWord", r, 32'h0F0F0F0F);

    // Idle stability
    r0 = rdata;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idleQuiet", {29'd0, stall, ready, err}, 32'd0);
      chk("idleRdata", rdata, r0);
    end
    cyc();

    // LATENCY=1, requests held continuously
    for (int k = 0; k < 6; k++) begin
      MemWrite1 = 1'b1; addr1 = 32'h8; wdata1 = 32'h100 + k;
      @(negedge clk);
      chk("lat1Ready", {31'd0, ready1}, k & 1);
      chk("lat1Stall", {31'd0, stall1}, (k & 1) ^ 1);
      cyc();
    end
    MemWrite1 = 1'b0;
    cyc();
    MemRead1 = 1'b1; addr1 = 32'h8;
    cyc();
    MemRead1 = 1'b0;
    chk("lat1LoadReady", {31'd0, ready1}, 32'd1);
    chk("lat1LoadErr", {31'd0, err1}, 32'd0);
    chk("lat1NoDup", rdata1, 32'h104);
    cyc();
    chk("lat1Idle", {30'd0, ready1, stall1}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

- Multi-cycle data-memory slave; the responding end of the MemRead/MemWrite control interface driven by the main decode controller.
- Sits between the ALU result/rs2 datapath and the MemtoReg write-back mux.
- Accepts one load or store request, services it after a fixed latency, returns a one-cycle `ready` pulse.
- Holds the pipeline with `stall` until the access completes.

## Interface
- `ADDR_W`, default 8: word-index bits; depth = 2^ADDR_W 32-bit words.
- `LATENCY`, default 2: cycles from request acceptance to `ready`; legal range 1..15.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high.
- `MemRead`  in  1  load request (from controller).
- `MemWrite`  in  1  store request (from controller).
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2).
- `rdata`  out  32  load data; registered.
- `ready`  out  1  single-cycle completion pulse; registered.
- `err`  out  1  completion error flag, valid only while `ready`=1; registered.
- `stall`  out  1  pipeline hold; combinational from state and request inputs.

## Operation
- State machine: IDLE, BUSY, DONE; 4-bit down-counter `cnt`.
- IDLE:
  - If `MemRead|MemWrite`, capture `addr`, `wdata` and op, then go to BUSY with `cnt`=LATENCY-1.
  - If LATENCY=1, go directly to DONE.
  - Otherwise stay in IDLE.
- BUSY:
  - Inputs ignored; decrement `cnt` each cycle.
  - When `cnt` reaches 1, the next state is DONE.
- DONE:
  - `ready`=1 for exactly this cycle.
  - Always return to IDLE; inputs present during DONE are never accepted, since they belong to the instruction being retired.
- Commit happens on the edge entering DONE:
  - Store: mem[idx] <= captured wdata.
  - Load: `rdata` <= mem[idx].
- idx = captured addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo 4*2^ADDR_W bytes.
- Misaligned access (captured addr[1:0] != 0): request still completes with `ready`=1 and `err`=1. The store is suppressed and `rdata` keeps its old value.
- Both `MemRead` and `MemWrite` high in IDLE: request accepted, treated as an error access. `err`=1, no write, `rdata` unchanged.
- `rdata` holds its value until the next successful load completes. Stores never change `rdata`.
- `err` is 0 whenever `ready` is 0.
- `stall` = (state==IDLE & (MemRead|MemWrite)) | state==BUSY; it is 0 in DONE.
- Memory array is not reset; contents persist across reset.

## Timing
- Reset values:
  - state IDLE, `cnt` 0.
  - `rdata` 32'h0, `ready` 0, `err` 0.
  - `stall` forced 0 while `reset`=1.
- Reset asserted mid-access (BUSY or DONE):
  - Access abandoned; no memory write occurs unless the commit edge already passed.
  - Outputs return to reset values immediately (asynchronous).
- Latency: request present in IDLE at cycle N means `ready`=1 in cycle N+LATENCY.
- Throughput: at most one access per LATENCY+1 cycles.
- The next request is sampled no earlier than cycle N+LATENCY+1.
- Read-after-write to the same word on consecutive accesses returns the new data.

## Test plan
- Store then load, LATENCY=2: store addr 0x10, wdata 0xDEADBEEF in cycle 0 -> `ready` in cycle 2, `stall` high cycles 0–1. Load addr 0x10 in cycle 3 -> `ready` in cycle 5, `rdata`=0xDEADBEEF, `err`=0.
- Misaligned and conflict:
  - Store addr 0x13 -> `ready`=1, `err`=1, word 0x10 unchanged on a later load.
  - MemRead=MemWrite=1 -> `err`=1, `rdata` unchanged.
- Wrap, ADDR_W=8: store 0x55 at addr 0x400 -> load addr 0x000 returns 0x00000055.
- Reset mid-op: store 0x12345678 to addr 0x20, assert `reset` in first BUSY cycle -> `ready` never pulses, word 0x20 keeps its prior value, `rdata`=0 and `stall`=0 during reset.
- LATENCY=1 back-to-back: requests held continuously -> `ready` pulses every 2nd cycle, one access per pulse, and no duplicate commit from inputs seen during DONE.
- Idle: no request for 10 cycles -> `stall`, `ready`, `err` stay 0 and `rdata` is stable.
